haz_ctrl: RTL and testbench
===========================

// Module: haz_ctrl
// PURPOSE
//  Hazard controller for the in-order MIPS pipeline; it sequences the decode stage.
//  A per-register scoreboard tracks destinations that are issued but not yet written back.
//  It stalls decode on a RAW dependency and bubbles (discards) the decode slot after a taken branch/jump.
//  Sits between dec_stg (dec_haz/haz_dec packets), the exec redirect and the writeback port.
// PARAMETERS
//  NREG      32  architectural register count; register 0 is never tracked
//  CNT_W     2   scoreboard counter width; max outstanding writes per reg = 2**CNT_W-1
//  FLUSH_CYC 1   cycles bubble stays high after a redirect (1..15)
// PORTS
//  clk          in   1   clock
//  resetn       in   1   asynchronous, active-low reset
//  rs_vld       in   1   decode instruction reads rs
//  rt_vld       in   1   decode instruction reads rt
//  rs           in   5   decode rs index
//  rt           in   5   decode rt index
//  issue_vld    in   1   dec_exec_vld & dec_exec_rdy (instruction leaves decode)
//  issue_dst_vld in  1   issuing instruction writes a register
//  issue_dst    in   5   issuing instruction destination
//  wrb_vld      in   1   writeback commits a register
//  wrb_addr     in   5   writeback destination
//  br_redirect  in   1   exec resolved taken branch/jump (1-cycle pulse)
//  stall        out  1   hold decode (haz_dec_pkt.stall)
//  bubble       out  1   discard decode slot (haz_dec_pkt.bubble)
//  flush_ftch   out  1   kill fetch-side in-flight packet, 1 cycle
//  sb_err       out  1   sticky: scoreboard underflow/overflow detected
// BEHAVIOUR
//  Reset: cnt[*]=0, FSM=IDLE, flush counter=0, sb_err=0 -> stall=bubble=flush_ftch=0.
//  Scoreboard update (registered, 1 cycle):
//   inc = issue_vld & issue_dst_vld & issue_dst!=0; dec = wrb_vld & wrb_addr!=0.
//   inc/dec on different regs: both apply. Same reg, same cycle: cnt unchanged.
//   dec with cnt==0: cnt stays 0, sb_err<=1. inc with cnt==max: cnt holds, sb_err<=1.
//  Stall (combinational from current state, no writeback bypass):
//   raw  = (rs_vld & rs!=0 & cnt[rs]!=0) | (rt_vld & rt!=0 & cnt[rt]!=0)
//   full = issue_dst_vld & issue_dst!=0 & cnt[issue_dst]==max
//   stall = (raw | full) & ~bubble. A dependency clears the cycle after wrb_vld updates cnt.
//  Redirect FSM: IDLE -> FLUSH on br_redirect; load fcnt=FLUSH_CYC-1.
//   FLUSH: bubble=1; flush_ftch=1 only in the first FLUSH cycle; fcnt-- each cycle; FLUSH->IDLE when fcnt==0.
//   br_redirect while in FLUSH: reload fcnt and re-pulse flush_ftch next cycle.
//   bubble has priority: stall forced 0 while bubble=1.
//   Entries already issued into exec still complete (they were on the correct path), so cnt is not cleared.
//  Async reset mid-operation: all state cleared immediately; stall/bubble drop combinationally.
//  Outputs carry no cycle latency from decode inputs; only state updates are registered.
// TESTING
//  1 Reset, rs_vld=1 rs=5 -> stall=0, bubble=0, sb_err=0.
//  2 Issue dst=8; next cycle rs=8 rs_vld=1 -> stall=1. wrb_addr=8 at cycle t -> stall=0 at t+1.
//  3 Issue dst=0, then rt=0 rt_vld=1 -> stall=0; cnt[0] never changes.
//  4 Issue dst=3 and wrb_addr=3 in the same cycle with cnt[3]=1 -> cnt[3] stays 1, stall persists.
//  5 br_redirect pulse, FLUSH_CYC=2, plus a RAW present -> bubble=1 for 2 cycles, flush_ftch=1 only in cycle 1, stall=0; then stall=1.
//  6 Three issues to r9 with CNT_W=2 -> 4th attempt: full stall=1. wrb to r4 with cnt=0 -> sb_err=1, sticky until reset.

Source files
------------

// File: rtl/haz_ctrl.sv
// Hazard controller for the in-order pipeline decode stage.
// Keeps a per-register count of issued-but-not-written-back destinations,
// stalls decode on RAW dependencies or a saturated counter, and bubbles the
// decode slot for FLUSH_CYC cycles after a taken branch/jump redirect.
module haz_ctrl #(
    parameter int NREG      = 32,
    parameter int CNT_W     = 2,
    parameter int FLUSH_CYC = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rs_vld,
    input  logic       rt_vld,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       issue_vld,
    input  logic       issue_dst_vld,
    input  logic [4:0] issue_dst,
    input  logic       wrb_vld,
    input  logic [4:0] wrb_addr,
    input  logic       br_redirect,
    output logic       stall,
    output logic       bubble,
    output logic       flush_ftch,
    output logic       sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       FCNT_LOAD = 4'(FLUSH_CYC - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             sb_err_q, sb_err_d;
    state_t           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic             first_q, first_d;

    logic             inc_s, dec_s;
    logic             raw_s, full_s;

    assign inc_s = issue_vld & issue_dst_vld & (issue_dst != 5'd0);
    assign dec_s = wrb_vld & (wrb_addr != 5'd0);

    // Scoreboard next-state: apply issue increments and writeback decrements,
    // flagging underflow/overflow instead of wrapping.
    always_comb begin
        logic inc_hit;
        logic dec_hit;
        sb_err_d = sb_err_q;
        cnt_d[0] = CNT_ZERO;
        for (int i = 1; i < NREG; i++) begin
            inc_hit  = inc_s & (issue_dst == i[4:0]);
            dec_hit  = dec_s & (wrb_addr == i[4:0]);
            cnt_d[i] = cnt_q[i];
            if (inc_hit && !dec_hit) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (dec_hit && !inc_hit) begin
                if (cnt_q[i] == CNT_ZERO) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Scoreboard counters and sticky error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

    // Redirect FSM next-state: a redirect (re)loads the flush counter and
    // marks the following cycle as the fetch-kill cycle.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        first_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (br_redirect) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FCNT_LOAD;
                    first_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (br_redirect) begin
                    fcnt_d  = FCNT_LOAD;
                    first_d = 1'b1;
                end else if (fcnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = 4'd0;
            end
        endcase
    end

    // Redirect FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            fcnt_q  <= 4'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            first_q <= first_d;
        end
    end

    // Dependency detection from current scoreboard state (no writeback bypass).
    always_comb begin
        raw_s  = (rs_vld & (rs != 5'd0) & (cnt_q[rs] != CNT_ZERO)) |
                 (rt_vld & (rt != 5'd0) & (cnt_q[rt] != CNT_ZERO));
        full_s = issue_dst_vld & (issue_dst != 5'd0) & (cnt_q[issue_dst] == CNT_MAX);
    end

    // Output decode: bubble and fetch kill come straight from registered state;
    // a bubbled slot never stalls.
    always_comb begin
        bubble     = (state_q == ST_FLUSH);
        flush_ftch = first_q;
        sb_err     = sb_err_q;
        stall      = (raw_s | full_s) & ~bubble;
    end

endmodule

// File: tb/tb_haz_ctrl.sv
// Self-checking bench for haz_ctrl: a table of directed vectors, hand-written
// redirect/saturation/reset sequences, then randomized traffic, all compared
// against a behavioural model of outstanding writes and remaining bubble cycles.
module tb_haz_ctrl;

    localparam int FLUSH_N = 2;
    localparam int CNTW    = 2;
    localparam int MAXC    = (1 << CNTW) - 1;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rs_vld, rt_vld, issue_vld, issue_dst_vld, wrb_vld, br_redirect;
    logic [4:0] rs, rt, issue_dst, wrb_addr;
    logic       stall, bubble, flush_ftch, sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    haz_ctrl #(.NREG(32), .CNT_W(CNTW), .FLUSH_CYC(FLUSH_N)) dut (
        .clk(clk), .resetn(resetn),
        .rs_vld(rs_vld), .rt_vld(rt_vld), .rs(rs), .rt(rt),
        .issue_vld(issue_vld), .issue_dst_vld(issue_dst_vld), .issue_dst(issue_dst),
        .wrb_vld(wrb_vld), .wrb_addr(wrb_addr), .br_redirect(br_redirect),
        .stall(stall), .bubble(bubble), .flush_ftch(flush_ftch), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rs_vld;
        logic [4:0] rs;
        logic       rt_vld;
        logic [4:0] rt;
        logic       iv;
        logic       idv;
        logic [4:0] idst;
        logic       wv;
        logic [4:0] wa;
        logic       br;
        logic       chk;
        logic [3:0] e;      // {stall, bubble, flush_ftch, sb_err}
    } vec_t;

    // Behavioural model: outstanding writes per register, bubble cycles left,
    // whether the coming cycle is the fetch-kill cycle, sticky error.
    int m_cnt [32];
    int m_left;
    bit m_pulse;
    bit m_err;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_left  = 0;
        m_pulse = 1'b0;
        m_err   = 1'b0;
    endfunction

    function automatic vec_t mk(input bit rsv, input int rsi, input bit rtv, input int rti,
                                input bit iv, input bit idv, input int idst,
                                input bit wv, input int wa, input bit br, input int e);
        vec_t v;
        v.rs_vld = rsv; v.rs = 5'(rsi); v.rt_vld = rtv; v.rt = 5'(rti);
        v.iv = iv; v.idv = idv; v.idst = 5'(idst);
        v.wv = wv; v.wa = 5'(wa); v.br = br;
        v.chk = (e >= 0);
        v.e   = 4'(e);
        return v;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        rs_vld = 1'b0; rs = 5'd0; rt_vld = 1'b0; rt = 5'd0;
        issue_vld = 1'b0; issue_dst_vld = 1'b0; issue_dst = 5'd0;
        wrb_vld = 1'b0; wrb_addr = 5'd0; br_redirect = 1'b0;
    endtask

    // One clock cycle: drive, check against model (and table constants), advance model.
    task automatic step(input vec_t v, input string tag);
        bit raw, full, e_bub, e_stall, inc, dec;
        @(negedge clk);
        rs_vld = v.rs_vld; rs = v.rs; rt_vld = v.rt_vld; rt = v.rt;
        issue_vld = v.iv; issue_dst_vld = v.idv; issue_dst = v.idst;
        wrb_vld = v.wv; wrb_addr = v.wa; br_redirect = v.br;
        #2;
        raw     = (v.rs_vld && v.rs != 0 && m_cnt[v.rs] > 0) ||
                  (v.rt_vld && v.rt != 0 && m_cnt[v.rt] > 0);
        full    = v.idv && v.idst != 0 && m_cnt[v.idst] == MAXC;
        e_bub   = (m_left > 0);
        e_stall = (raw || full) && !e_bub;
        chk({tag, ".stall"},  stall,      e_stall);
        chk({tag, ".bubble"}, bubble,     e_bub);
        chk({tag, ".flush"},  flush_ftch, m_pulse);
        chk({tag, ".sb_err"}, sb_err,     m_err);
        if (v.chk) begin
            chk({tag, ".k_stall"},  stall,      v.e[3]);
            chk({tag, ".k_bubble"}, bubble,     v.e[2]);
            chk({tag, ".k_flush"},  flush_ftch, v.e[1]);
            chk({tag, ".k_sb_err"}, sb_err,     v.e[0]);
        end
        inc = v.iv && v.idv && v.idst != 0;
        dec = v.wv && v.wa != 0;
        if (!(inc && dec && v.idst == v.wa)) begin
            if (inc) begin
                if (m_cnt[v.idst] == MAXC) m_err = 1'b1;
                else m_cnt[v.idst]++;
            end
            if (dec) begin
                if (m_cnt[v.wa] == 0) m_err = 1'b1;
                else m_cnt[v.wa]--;
            end
        end
        if (v.br) begin
            m_left  = FLUSH_N;
            m_pulse = 1'b1;
        end else begin
            if (m_left > 0) m_left--;
            m_pulse = 1'b0;
        end
    endtask

    // Pull reset mid-cycle with the current inputs still applied; outputs must drop at once.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk({tag, ".rst_stall"},  stall,      1'b0);
        chk({tag, ".rst_bubble"}, bubble,     1'b0);
        chk({tag, ".rst_flush"},  flush_ftch, 1'b0);
        chk({tag, ".rst_sb_err"}, sb_err,     1'b0);
        model_reset();
        @(negedge clk);
        drive_idle();
        #2;
        resetn = 1'b1;
    endtask

    vec_t tbl [11];

    initial begin
        vec_t v;
        int   wa;
        drive_idle();
        model_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b1;

        // code = {stall, bubble, flush_ftch, sb_err}
        tbl[0]  = mk(1,5, 0,0, 0,0,0, 0,0, 0, 4'b0000); // reset state, no deps
        tbl[1]  = mk(0,0, 0,0, 1,1,8, 0,0, 0, 4'b0000); // issue r8
        tbl[2]  = mk(1,8, 0,0, 0,0,0, 1,8, 0, 4'b1000); // RAW on r8, wrb r8 now
        tbl[3]  = mk(1,8, 0,0, 0,0,0, 0,0, 0, 4'b0000); // cleared one cycle later
        tbl[4]  = mk(0,0, 0,0, 1,1,0, 0,0, 0, 4'b0000); // issue r0: untracked
        tbl[5]  = mk(0,0, 1,0, 0,0,0, 0,0, 0, 4'b0000); // read r0
        tbl[6]  = mk(0,0, 0,0, 1,1,3, 0,0, 0, 4'b0000); // issue r3
        tbl[7]  = mk(0,0, 1,3, 1,1,3, 1,3, 0, 4'b1000); // issue+wrb r3 same cycle
        tbl[8]  = mk(0,0, 1,3, 0,0,0, 0,0, 0, 4'b1000); // r3 still outstanding
        tbl[9]  = mk(0,0, 1,3, 0,0,0, 1,3, 0, 4'b1000); // wrb r3
        tbl[10] = mk(0,0, 1,3, 0,0,0, 0,0, 0, 4'b0000); // dependency gone
        for (int i = 0; i < 11; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Redirect with a RAW pending, then a second redirect inside FLUSH.
        step(mk(0,0, 0,0, 1,1,7, 0,0, 0, 4'b0000), "br_a");
        step(mk(1,7, 0,0, 0,0,0, 0,0, 1, 4'b1000), "br_b");
        step(mk(1,7, 0,0, 0,0,0, 0,0, 0, 4'b0110), "br_c");
        step(mk(1,7, 0,0, 0,0,0, 0,0, 0, 4'b0100), "br_d");
        step(mk(1,7, 0,0, 0,0,0, 0,0, 0, 4'b1000), "br_e");
        step(mk(1,7, 0,0, 0,0,0, 0,0, 1, 4'b1000), "br_f");
        step(mk(1,7, 0,0, 0,0,0, 0,0, 1, 4'b0110), "br_g");
        step(mk(1,7, 0,0, 0,0,0, 0,0, 0, 4'b0110), "br_h");
        step(mk(1,7, 0,0, 0,0,0, 0,0, 0, 4'b0100), "br_i");
        step(mk(1,7, 0,0, 0,0,0, 1,7, 0, 4'b1000), "br_j");
        step(mk(1,7, 0,0, 0,0,0, 0,0, 0, 4'b0000), "br_k");

        // Saturation stall, then underflow sets the sticky error.
        for (int i = 0; i < 3; i++) step(mk(0,0, 0,0, 1,1,9, 0,0, 0, 4'b0000), "sat_iss");
        step(mk(0,0, 0,0, 0,1,9, 0,0, 0, 4'b1000), "sat_full");
        step(mk(0,0, 0,0, 0,0,0, 1,4, 0, 4'b0000), "udf_wrb");
        step(mk(0,0, 0,0, 0,0,0, 0,0, 0, 4'b0001), "udf_err");
        step(mk(0,0, 0,0, 0,0,0, 0,0, 0, 4'b0001), "udf_sticky");
        async_reset("ar1");

        // Overflow: issuing into a saturated register holds it and flags error.
        for (int i = 0; i < 3; i++) step(mk(0,0, 0,0, 1,1,9, 0,0, 0, 4'b0000), "ovf_iss");
        step(mk(0,0, 0,0, 1,1,9, 0,0, 0, 4'b1000), "ovf_try");
        step(mk(0,0, 0,0, 0,1,9, 0,0, 0, 4'b1001), "ovf_hold");
        step(mk(0,0, 0,0, 0,0,0, 1,9, 0, 4'b0001), "ovf_wrb");
        step(mk(0,0, 0,0, 0,1,9, 0,0, 0, 4'b0001), "ovf_notfull");
        step(mk(1,9, 0,0, 0,0,0, 0,0, 0, 4'b1001), "ovf_raw");
        async_reset("ar2");

        // Reset in the middle of a bubble.
        step(mk(0,0, 0,0, 0,0,0, 0,0, 1, 4'b0000), "rb_br");
        step(mk(0,0, 0,0, 0,0,0, 0,0, 0, 4'b0110), "rb_bub");
        async_reset("ar3");

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            v = mk($urandom_range(1,0), $urandom_range(7,0), $urandom_range(1,0), $urandom_range(7,0),
                   ($urandom_range(2,0) == 0), $urandom_range(1,0), $urandom_range(7,0),
                   ($urandom_range(2,0) == 0), 0, ($urandom_range(9,0) == 0), -1);
            wa = $urandom_range(7,0);
            for (int t = 0; t < 8 && m_cnt[wa] == 0 && $urandom_range(19,0) != 0; t++)
                wa = $urandom_range(7,1);
            v.wa = 5'(wa);
            step(v, $sformatf("rnd%0d", n));
            if (n == 400) async_reset("ar_rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
